// File: rtl/config_pkg.sv
// Core configuration slice: PMA rule tables, range check and the
// attribute bundle shared by the PMA walker, caches and LSU.
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
    int unsigned NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
    int unsigned NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  // 65-bit end so regions touching the top of the space do not wrap
  function automatic logic range_check(
    input logic [63:0] base,
    input logic [63:0] len,
    input logic [63:0] address
  );
    return (address >= base) &&
           ({1'b0, address} < (65'(base) + 65'(len)));
  endfunction

  typedef struct packed {
    logic cacheable;
    logic nonidempotent;
    logic executable;
  } pma_attr_t;

endpackage

// File: rtl/pma_rule_match.sv
// Single PMA rule comparator: hit when addr lies in [base, base+len).
module pma_rule_match
  import config_pkg::*;
(
  input  logic [63:0] base_i,
  input  logic [63:0] len_i,
  input  logic [63:0] addr_i,
  output logic        hit_o
);

  assign hit_o = range_check(base_i, len_i, addr_i);

endmodule

// File: rtl/pma_walker.sv
// Sequential PMA lookup: walks the three rule tables one index per
// cycle with sticky hit flags and returns one attribute response.
module pma_walker
  import config_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output pma_attr_t   resp_attr_o
);

  localparam int unsigned NNI = CVA6Cfg.NrNonIdempotentRules;
  localparam int unsigned NEX = CVA6Cfg.NrExecuteRegionRules;
  localparam int unsigned NCA = CVA6Cfg.NrCachedRegionRules;
  localparam int unsigned NM  = (NNI > NEX) ? NNI : NEX;
  localparam int unsigned N   = (NM > NCA) ? NM : NCA;
  localparam int IW = $clog2(NrMaxRules);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] Last = IW'((N > 0) ? N - 1 : 0);
  localparam logic ExecAll = (NEX == 0);

  typedef enum logic [1:0] {
    PMA_IDLE,
    PMA_WALK,
    PMA_RESP
  } state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [63:0]   addr_q;
  logic          ni_q, ex_q, ca_q;
  logic          ni_hit, ex_hit, ca_hit;
  logic          ni_on, ex_on, ca_on;

  pma_rule_match u_ni (
    .base_i (CVA6Cfg.NonIdempotentAddrBase[idx_q]),
    .len_i  (CVA6Cfg.NonIdempotentLength[idx_q]),
    .addr_i (addr_q),
    .hit_o  (ni_hit)
  );

  pma_rule_match u_ex (
    .base_i (CVA6Cfg.ExecuteRegionAddrBase[idx_q]),
    .len_i  (CVA6Cfg.ExecuteRegionLength[idx_q]),
    .addr_i (addr_q),
    .hit_o  (ex_hit)
  );

  pma_rule_match u_ca (
    .base_i (CVA6Cfg.CachedRegionAddrBase[idx_q]),
    .len_i  (CVA6Cfg.CachedRegionLength[idx_q]),
    .addr_i (addr_q),
    .hit_o  (ca_hit)
  );

  // tables shorter than N stop contributing past their last rule
  assign ni_on = ni_hit && ({1'b0, idx_q} < CW'(NNI));
  assign ex_on = ex_hit && ({1'b0, idx_q} < CW'(NEX));
  assign ca_on = ca_hit && ({1'b0, idx_q} < CW'(NCA));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= PMA_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      ni_q         <= 1'b0;
      ex_q         <= 1'b0;
      ca_q         <= 1'b0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_attr_o  <= '0;
    end else begin
      unique case (state_q)
        PMA_IDLE: begin
          if (req_valid_i && !flush_i) begin
            addr_q      <= req_addr_i;
            idx_q       <= '0;
            ni_q        <= 1'b0;
            ex_q        <= 1'b0;
            ca_q        <= 1'b0;
            req_ready_o <= 1'b0;
            if (N > 0) begin
              state_q <= PMA_WALK;
            end else begin
              state_q      <= PMA_RESP;
              resp_valid_o <= 1'b1;
              resp_attr_o  <= '{cacheable: 1'b0,
                                 nonidempotent: 1'b0,
                                 executable: ExecAll};
            end
          end
        end
        PMA_WALK: begin
          if (flush_i) begin
            state_q     <= PMA_IDLE;
            req_ready_o <= 1'b1;
          end else begin
            ni_q <= ni_q | ni_on;
            ex_q <= ex_q | ex_on;
            ca_q <= ca_q | ca_on;
            if (idx_q == Last) begin
              state_q      <= PMA_RESP;
              resp_valid_o <= 1'b1;
              resp_attr_o  <= '{cacheable: ca_q | ca_on,
                                 nonidempotent: ni_q | ni_on,
                                 executable: ExecAll | ex_q | ex_on};
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        PMA_RESP: begin
          if (flush_i || resp_ready_i) begin
            state_q      <= PMA_IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
          end
        end
        default: begin
          state_q      <= PMA_IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pma_walker.sv
// Randomized bench for pma_walker: a populated config and the empty
// default config, both checked against a region-list reference model.
module tb_pma_walker;
  import config_pkg::*;

  localparam logic [63:0] NIB [2] = '{64'h0, 64'h1000_0000};
  localparam logic [63:0] NIL [2] = '{64'h1000, 64'h1000_0000};
  localparam logic [63:0] EXB [1] = '{64'h8000_0000};
  localparam logic [63:0] EXL [1] = '{64'h4000_0000};
  localparam logic [63:0] CAB [2] = '{64'h8000_0000,
                                      64'hFFFF_FFFF_FFFF_F000};
  localparam logic [63:0] CAL [2] = '{64'h4000_0000, 64'h2000};

  function automatic cva6_cfg_t mk_cfg();
    cva6_cfg_t c;
    c = cva6_cfg_empty;
    c.NrNonIdempotentRules = 2;
    c.NrExecuteRegionRules = 1;
    c.NrCachedRegionRules  = 2;
    for (int i = 0; i < 2; i++) begin
      c.NonIdempotentAddrBase[i] = NIB[i];
      c.NonIdempotentLength[i]   = NIL[i];
      c.CachedRegionAddrBase[i]  = CAB[i];
      c.CachedRegionLength[i]    = CAL[i];
    end
    c.ExecuteRegionAddrBase[0] = EXB[0];
    c.ExecuteRegionLength[0]   = EXL[0];
    return c;
  endfunction

  localparam cva6_cfg_t MainCfg = mk_cfg();

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic req_valid, flush, resp_ready;
  logic [63:0] req_addr;
  logic m_rdy, m_vld, z_rdy, z_vld;
  pma_attr_t m_attr, z_attr;
  logic rdy, vld;
  pma_attr_t attr;

  always #5 clk = ~clk;

  pma_walker #(.CVA6Cfg(MainCfg)) u_main (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush & ~sel),
    .req_valid_i  (req_valid & ~sel),
    .req_ready_o  (m_rdy),
    .req_addr_i   (req_addr),
    .resp_valid_o (m_vld),
    .resp_ready_i (resp_ready & ~sel),
    .resp_attr_o  (m_attr)
  );

  pma_walker u_zero (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush & sel),
    .req_valid_i  (req_valid & sel),
    .req_ready_o  (z_rdy),
    .req_addr_i   (req_addr),
    .resp_valid_o (z_vld),
    .resp_ready_i (resp_ready & sel),
    .resp_attr_o  (z_attr)
  );

  assign rdy  = sel ? z_rdy : m_rdy;
  assign vld  = sel ? z_vld : m_vld;
  assign attr = sel ? z_attr : m_attr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit inside_rgn(logic [63:0] a, logic [63:0] b,
                                    logic [63:0] l);
    return (a >= b) && ((a - b) < l);
  endfunction

  function automatic pma_attr_t model(logic [63:0] a, logic zero);
    pma_attr_t r;
    r = '{cacheable: 1'b0, nonidempotent: 1'b0, executable: 1'b0};
    if (zero) begin
      r.executable = 1'b1;
      return r;
    end
    foreach (NIB[i]) if (inside_rgn(a, NIB[i], NIL[i])) r.nonidempotent = 1'b1;
    foreach (EXB[i]) if (inside_rgn(a, EXB[i], EXL[i])) r.executable = 1'b1;
    foreach (CAB[i]) if (inside_rgn(a, CAB[i], CAL[i])) r.cacheable = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] e [7];
    int k;
    e = '{64'h0, 64'h1000, 64'h1000_0000, 64'h2000_0000,
          64'h8000_0000, 64'hC000_0000, 64'hFFFF_FFFF_FFFF_F000};
    k = $urandom_range(0, 6);
    unique case ($urandom_range(0, 2))
      0: return {$urandom, $urandom};
      1: return e[k] + 64'($urandom_range(0, 2)) - 64'd1;
      default: return e[k] + 64'($urandom_range(0, 'h3fff));
    endcase
  endfunction

  task automatic lookup(input logic [63:0] a, input int hold);
    pma_attr_t exp, snap;
    int lat, expn;
    expn = sel ? 0 : 2;
    exp  = model(a, sel);
    @(negedge clk);
    check("rdy_idle", rdy, 1);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = '0;
    lat = 0;
    while (!vld && lat < 40) begin
      check("rdy_busy", rdy, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, expn);
    check("attr", attr, exp);
    check("rdy_resp", rdy, 0);
    snap = attr;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_addr  = ~a;
      @(negedge clk);
      check("hold_vld", vld, 1);
      check("hold_attr", attr, snap);
      check("hold_rdy", rdy, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("done_vld", vld, 0);
    check("done_rdy", rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, nv;
    sel = 1'b0;
    req_valid = 1'b0;
    flush = 1'b0;
    resp_ready = 1'b0;
    req_addr = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", m_rdy, 1);
    check("rst_vld", m_vld, 0);
    check("rst_attr", m_attr, 0);
    check("rst_zrdy", z_rdy, 1);
    rst_n = 1'b1;

    lookup(64'h8000_0100, 0);
    lookup(64'h1FFF_FFFF, 0);
    lookup(64'h2000_0000, 0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, 1);
    lookup(64'h0000_0FFF, 5);

    // back-to-back with ready tied high: one lookup per 4 cycles
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 64'h8000_0000;
    resp_ready = 1'b1;
    acc = 0;
    nv  = 0;
    for (int i = 0; i < 12; i++) begin
      if (rdy) acc++;
      if (vld) nv++;
      @(negedge clk);
    end
    check("b2b_acc", acc, 3);
    check("b2b_resp", nv, 3);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    resp_ready = 1'b0;

    // flush in first walk cycle
    req_valid = 1'b1;
    req_addr  = 64'h8000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_rdy", rdy, 1);
    check("flush_vld", vld, 0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vld) nv++;
    end
    check("flush_quiet", nv, 0);

    // flush beats a request in idle
    flush     = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle_rdy", rdy, 1);

    // flush beats resp_ready in resp
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_flush_vld", vld, 1);
    flush      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
    resp_ready = 1'b0;
    check("flush_resp_vld", vld, 0);
    check("flush_resp_rdy", rdy, 1);

    // async reset mid-walk
    req_valid = 1'b1;
    req_addr  = 64'h8000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_rdy", rdy, 1);
    check("arst_vld", vld, 0);
    check("arst_attr", attr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", vld, 0);
    check("post_rst_rdy", rdy, 1);

    for (int i = 0; i < 40; i++) lookup(pick(), $urandom_range(0, 2));

    sel = 1'b1;
    lookup(64'h1234, 0);
    lookup(64'h8000_0100, 2);
    for (int i = 0; i < 6; i++) lookup(pick(), $urandom_range(0, 1));
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
